// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer and its song ROM.
package song_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_PAUSED
  } state_t;

  typedef struct packed {
    logic [5:0] note;
    logic       rest;
    logic [2:0] beats;
  } song_entry_t;

  // A zero beat count terminates a song.
  localparam song_entry_t END_MARKER = '{note: 6'd0, rest: 1'b0, beats: 3'd0};

  localparam logic [5:0] C4 = 6'd0;
  localparam logic [5:0] D4 = 6'd1;
  localparam logic [5:0] E4 = 6'd2;
  localparam logic [5:0] F4 = 6'd3;
  localparam logic [5:0] G4 = 6'd4;
  localparam logic [5:0] A4 = 6'd5;
  localparam logic [5:0] B4 = 6'd6;
  localparam logic [5:0] C5 = 6'd7;

  function automatic song_entry_t mk_entry(input logic [5:0] n, input logic r,
                                           input logic [2:0] b);
    song_entry_t e;
    e.note  = n;
    e.rest  = r;
    e.beats = b;
    return e;
  endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control and tone-path signals between the song sequencer and its controller.
interface song_sequencer_if;
  logic       start;
  logic       stop;
  logic       pause;
  logic       loop_en;
  logic [1:0] tempo_sel;
  logic [5:0] note_index;
  logic       play;
  logic       busy;
  logic [3:0] step;
  logic       done;

  modport master (
    output start, stop, pause, loop_en, tempo_sel,
    input  note_index, play, busy, step, done
  );

  modport slave (
    input  start, stop, pause, loop_en, tempo_sel,
    output note_index, play, busy, step, done
  );
endinterface

// File: rtl/song_rom.sv
// Combinational song table; SONG_SEL picks the melody, unused addresses read as end marker.
module song_rom
  import song_pkg::*;
#(
  parameter int SONG_SEL = 0,
  parameter int AW       = 4
) (
  input  logic [AW-1:0] addr,
  output song_entry_t   entry
);

  always_comb begin
    entry = END_MARKER;
    if (SONG_SEL == 1) begin
      case (int'(addr))
        0:       entry = mk_entry(F4, 1'b0, 3'd2);
        1:       entry = mk_entry(C4, 1'b1, 3'd1);
        2:       entry = mk_entry(C5, 1'b0, 3'd1);
        default: entry = END_MARKER;
      endcase
    end else begin
      // Scale run up, a short phrase, and a resolve back to C4.
      case (int'(addr))
        0:       entry = mk_entry(C4, 1'b0, 3'd1);
        1:       entry = mk_entry(D4, 1'b0, 3'd1);
        2:       entry = mk_entry(E4, 1'b0, 3'd1);
        3:       entry = mk_entry(F4, 1'b0, 3'd1);
        4:       entry = mk_entry(G4, 1'b0, 3'd2);
        5:       entry = mk_entry(C4, 1'b1, 3'd1);
        6:       entry = mk_entry(G4, 1'b0, 3'd2);
        7:       entry = mk_entry(A4, 1'b0, 3'd1);
        8:       entry = mk_entry(B4, 1'b0, 3'd1);
        9:       entry = mk_entry(C5, 1'b0, 3'd2);
        10:      entry = mk_entry(C4, 1'b1, 3'd1);
        11:      entry = mk_entry(C5, 1'b0, 3'd1);
        12:      entry = mk_entry(G4, 1'b0, 3'd1);
        13:      entry = mk_entry(E4, 1'b0, 3'd1);
        14:      entry = mk_entry(C4, 1'b0, 3'd3);
        default: entry = END_MARKER;
      endcase
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Walks the song ROM, timing each entry in beats plus an articulation gap, and drives note/play.
module song_sequencer
  import song_pkg::*;
#(
  parameter int BEAT_TICKS = 25_000_000,
  parameter int GAP_TICKS  = 2_500_000,
  parameter int SONG_LEN   = 16,
  parameter int SONG_SEL   = 0
) (
  input  logic            clk,
  input  logic            rst,
  song_sequencer_if.slave bus
);

  localparam int SW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  localparam int PW = $clog2(BEAT_TICKS + 1);
  localparam int DW = 3 + ((BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1);
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(SONG_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  state_t        state, ret_state, nat_next;
  logic          adv_step;
  logic [SW-1:0] step_cnt;
  logic          wrapped;
  logic [PW-1:0] period_q;
  logic [2:0]    beats_q;
  logic          rest_q;
  logic [DW-1:0] dur_cnt, dur_last;
  logic [GW-1:0] gap_cnt;
  logic [5:0]    note_q;
  logic          play_q, busy_q, done_q;
  song_entry_t   rom_entry;

  song_rom #(.SONG_SEL(SONG_SEL), .AW(SW)) u_rom (
    .addr  (step_cnt),
    .entry (rom_entry)
  );

  function automatic logic [PW-1:0] beat_period(input logic [1:0] ts);
    logic [PW-1:0] p;
    p = PW'(BEAT_TICKS >> ts);
    if (p == '0) p = PW'(1);
    return p;
  endfunction

  assign dur_last = DW'(beats_q) * DW'(period_q) - DW'(1);

  // Where PLAY/GAP would go on their own; a pause saves this as the resume state.
  always_comb begin
    nat_next = state;
    adv_step = 1'b0;
    case (state)
      ST_PLAY: begin
        if (dur_cnt == dur_last) begin
          if (GAP_TICKS == 0) begin
            nat_next = ST_LOAD;
            adv_step = 1'b1;
          end else begin
            nat_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          nat_next = ST_LOAD;
          adv_step = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ret_state <= ST_IDLE;
      step_cnt  <= '0;
      wrapped   <= 1'b0;
      period_q  <= '0;
      beats_q   <= '0;
      rest_q    <= 1'b0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
      note_q    <= '0;
      play_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state     <= ST_IDLE;
        ret_state <= ST_IDLE;
        step_cnt  <= '0;
        wrapped   <= 1'b0;
        dur_cnt   <= '0;
        gap_cnt   <= '0;
        note_q    <= '0;
        play_q    <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              state    <= ST_LOAD;
              step_cnt <= '0;
              wrapped  <= 1'b0;
              busy_q   <= 1'b1;
            end
          end
          ST_LOAD: begin
            period_q <= beat_period(bus.tempo_sel);
            rest_q   <= rom_entry.rest;
            beats_q  <= rom_entry.beats;
            dur_cnt  <= '0;
            if (rom_entry.beats == '0 || wrapped) begin
              step_cnt <= '0;
              wrapped  <= 1'b0;
              if (!bus.loop_en) begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                note_q <= '0;
              end
            end else begin
              state  <= ST_PLAY;
              note_q <= rom_entry.note;
              play_q <= !rom_entry.rest;
            end
          end
          ST_PLAY, ST_GAP: begin
            if (state == ST_PLAY) dur_cnt <= (nat_next == ST_PLAY) ? dur_cnt + 1'b1 : '0;
            gap_cnt <= (state == ST_GAP && nat_next == ST_GAP) ? gap_cnt + 1'b1 : '0;
            if (adv_step) begin
              if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                wrapped  <= 1'b1;
              end else begin
                step_cnt <= step_cnt + 1'b1;
              end
            end
            // The pause cycle itself still counts toward the entry's duration.
            if (bus.pause) begin
              state     <= ST_PAUSED;
              ret_state <= nat_next;
              play_q    <= 1'b0;
            end else begin
              state  <= nat_next;
              play_q <= (nat_next == ST_PLAY) && !rest_q;
            end
          end
          ST_PAUSED: begin
            if (bus.pause) begin
              state  <= ret_state;
              play_q <= (ret_state == ST_PLAY) && !rest_q;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.note_index = note_q;
  assign bus.play       = play_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.step       = 4'(step_cnt);

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed scenarios plus random pulses against a timeline model.
module tb_song_sequencer;

  logic clk;
  logic rst;

  song_sequencer_if bus ();

  song_sequencer #(
    .BEAT_TICKS (8),
    .GAP_TICKS  (2),
    .SONG_LEN   (16),
    .SONG_SEL   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;

  // Test song: F4 x2 beats, rest x1, C5 x1, end.
  int s_note  [4] = '{3, 0, 7, 0};
  int s_rest  [4] = '{0, 1, 0, 0};
  int s_beats [4] = '{2, 1, 1, 0};
  localparam int GAP  = 2;
  localparam int BEAT = 8;

  // Model: phase 0 idle, 1 load, 2 sounding, 3 gap, 4 paused; m_rem = cycles left in phase.
  int m_ph, m_saved, m_idx, m_wr, m_rem, m_note, m_rest, m_done;

  int play_cnt, last_play, done_cnt, done_cyc;
  int win_lo = -1, win_hi = -1, win_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_update();
    int b, p, nat;
    if (rst) begin
      m_ph = 0; m_saved = 0; m_idx = 0; m_wr = 0;
      m_rem = 0; m_note = 0; m_rest = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (bus.stop) begin
      m_ph = 0; m_idx = 0; m_wr = 0; m_note = 0;
      return;
    end
    case (m_ph)
      0: if (bus.start) begin m_ph = 1; m_idx = 0; m_wr = 0; end
      1: begin
        b = (m_idx < 4) ? s_beats[m_idx] : 0;
        if (b == 0 || m_wr != 0) begin
          m_idx = 0; m_wr = 0;
          if (!bus.loop_en) begin m_ph = 0; m_done = 1; m_note = 0; end
        end else begin
          p = BEAT >> bus.tempo_sel;
          if (p < 1) p = 1;
          m_ph = 2; m_rem = b * p;
          m_note = s_note[m_idx]; m_rest = s_rest[m_idx];
        end
      end
      2, 3: begin
        nat = m_ph;
        m_rem--;
        if (m_rem == 0) begin
          if (m_ph == 2 && GAP > 0) begin
            nat = 3; m_rem = GAP;
          end else begin
            nat = 1; m_idx++;
            if (m_idx == 16) begin m_idx = 0; m_wr = 1; end
          end
        end
        if (bus.pause) begin m_saved = nat; m_ph = 4; end
        else m_ph = nat;
      end
      4: if (bus.pause) m_ph = m_saved;
      default: m_ph = 0;
    endcase
  endtask

  task automatic clr_track();
    play_cnt = 0; last_play = -1; done_cnt = 0; done_cyc = -1; win_cnt = 0;
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    chk("busy", 32'(bus.busy), 32'(m_ph != 0));
    chk("play", 32'(bus.play), 32'(m_ph == 2 && m_rest == 0));
    chk("note", 32'(bus.note_index), 32'(m_note));
    chk("step", 32'(bus.step), 32'(m_idx));
    chk("done", 32'(bus.done), 32'(m_done));
    if (bus.play === 1'b1) begin
      play_cnt++;
      last_play = cyc;
      if (cyc >= win_lo && cyc <= win_hi) win_cnt++;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) clk_step();
  endtask

  task automatic start_song();
    bus.start = 1'b1;
    cyc = 0;
    clr_track();
    clk_step();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    clk_step();
    bus.stop = 1'b0;
    repeat (2) clk_step();
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.loop_en = 1'b0; bus.tempo_sel = 2'd0;
    rst = 1'b1;
    clr_track();
    repeat (3) clk_step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_play", 32'(bus.play), 32'd0);
    chk("rst_step", 32'(bus.step), 32'd0);
    rst = 1'b0;
    repeat (2) clk_step();

    // Basic song
    start_song();
    chk("basic_load_busy", 32'(bus.busy), 32'd1);
    run_to(50);
    chk("basic_done_cyc", 32'(done_cyc), 32'd43);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);
    chk("basic_play_cnt", 32'(play_cnt), 32'd24);
    chk("basic_last_play", 32'(last_play), 32'd39);

    // Loop
    bus.loop_en = 1'b1;
    start_song();
    run_to(44);
    chk("loop_play", 32'(bus.play), 32'd1);
    chk("loop_note", 32'(bus.note_index), 32'd3);
    chk("loop_step", 32'(bus.step), 32'd0);
    run_to(90);
    chk("loop_no_done", 32'(done_cnt), 32'd0);
    bus.loop_en = 1'b0;
    pulse_stop();

    // Pause / resume
    win_lo = 7; win_hi = 20;
    start_song();
    run_to(6);
    bus.pause = 1'b1; clk_step(); bus.pause = 1'b0;
    run_to(20);
    bus.pause = 1'b1; clk_step(); bus.pause = 1'b0;
    run_to(34);
    chk("pause_window", 32'(win_cnt), 32'd0);
    chk("pause_play_cnt", 32'(play_cnt), 32'd16);
    chk("pause_last_play", 32'(last_play), 32'd31);
    win_lo = -1; win_hi = -1;
    pulse_stop();

    // Stop beats pause in the same cycle
    start_song();
    run_to(10);
    bus.stop = 1'b1; bus.pause = 1'b1; clk_step(); bus.stop = 1'b0; bus.pause = 1'b0;
    chk("stop_busy", 32'(bus.busy), 32'd0);
    chk("stop_step", 32'(bus.step), 32'd0);
    chk("stop_play", 32'(bus.play), 32'd0);
    chk("stop_done", 32'(bus.done), 32'd0);
    repeat (4) clk_step();
    start_song();
    run_to(3);
    chk("replay_step", 32'(bus.step), 32'd0);
    chk("replay_note", 32'(bus.note_index), 32'd3);
    pulse_stop();

    // Tempo 1: half beat period
    bus.tempo_sel = 2'd1;
    start_song();
    run_to(12);
    chk("tempo1_play_cnt", 32'(play_cnt), 32'd8);
    chk("tempo1_last_play", 32'(last_play), 32'd9);
    pulse_stop();

    // Tempo change mid-note applies at the next LOAD
    bus.tempo_sel = 2'd0;
    start_song();
    run_to(4);
    bus.tempo_sel = 2'd3;
    run_to(35);
    chk("tempo3_play_cnt", 32'(play_cnt), 32'd17);
    chk("tempo3_last_play", 32'(last_play), 32'd25);
    chk("tempo3_done_cyc", 32'(done_cyc), 32'd29);
    bus.tempo_sel = 2'd0;

    // Reset mid-song overrides a simultaneous start
    start_song();
    run_to(25);
    rst = 1'b1; bus.start = 1'b1; clk_step(); rst = 1'b0; bus.start = 1'b0;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_play", 32'(bus.play), 32'd0);
    chk("rst_mid_step", 32'(bus.step), 32'd0);
    chk("rst_mid_note", 32'(bus.note_index), 32'd0);
    clk_step();

    // Start while busy is ignored
    start_song();
    run_to(5);
    bus.start = 1'b1; clk_step(); bus.start = 1'b0;
    run_to(50);
    chk("busy_start_done_cyc", 32'(done_cyc), 32'd43);
    chk("busy_start_play_cnt", 32'(play_cnt), 32'd24);

    // Random pulses checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 19) == 0);
      bus.stop  = ($urandom_range(0, 149) == 0);
      bus.pause = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) bus.loop_en = ~bus.loop_en;
      if ($urandom_range(0, 63) == 0) bus.tempo_sel = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 599) == 0);
      clk_step();
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; rst = 1'b0;
    clk_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Plays a stored melody through the tone path without button-by-button stepping. It walks a small song table of {note, rest, beats} entries and times each entry against a beat counter. It drives `note_index` and `play` into the existing wave generator / I2S controller pair, replacing manual pitch adjust when the top-level selects song mode. It supports start, stop, pause/resume, loop and tempo scaling.

## Interface
Parameters:
- `BEAT_TICKS`, default 25_000_000: clk cycles per beat at tempo_sel=0 (250 ms at 100 MHz).
- `GAP_TICKS`, default 2_500_000: silent articulation cycles after every entry.
- `SONG_LEN`, default 16: table depth; the step counter is $clog2(SONG_LEN) bits wide.
- `SONG_SEL`, default 0: song_rom content select; 1 selects the short test song.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: main clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse; begins playback from step 0 when idle.
- `stop` in 1: single-cycle pulse; aborts playback.
- `pause` in 1: single-cycle pulse; toggles pause while busy.
- `loop_en` in 1: level; restart at step 0 instead of finishing.
- `tempo_sel` in 2: beat period = BEAT_TICKS >> tempo_sel, floored at 1.
- `note_index` out 6: note to wave generator, 0–7 used.
- `play` out 1: enables the I2S output.
- `busy` out 1: high in every state except IDLE.
- `step` out 4: current table address.
- `done` out 1: one-cycle pulse when a non-looping song completes.

## Operation
- States are IDLE, LOAD, PLAY, GAP and PAUSED.
- **IDLE:** outputs are at reset values. `start` moves to LOAD with step=0.
- **LOAD (1 cycle):**
  - Reads song_rom[step] combinationally and registers note, rest and beats into the entry registers.
  - Latches the beat period from `tempo_sel`. A tempo change mid-entry takes effect at the next LOAD.
  - If beats==0 (end marker) or step already wrapped past SONG_LEN-1:
    - with loop_en=1: step=0 and stay in LOAD for one more cycle;
    - with loop_en=0: go to IDLE and pulse `done` in the first IDLE cycle.
  - Otherwise go to PLAY.
- **PLAY:**
  - Lasts beats × beat_period cycles.
  - `play` = !rest; `note_index` = entry note (held during rests).
  - At expiry go to GAP.
- **GAP:**
  - Lasts GAP_TICKS cycles with play=0.
  - Then step++ and go to LOAD.
  - GAP_TICKS=0 skips GAP.
- **PAUSED:**
  - Entered from PLAY or GAP on `pause`.
  - The beat and duration counters freeze and play=0. The return state is saved.
  - `pause` again resumes into the saved state with counters unchanged.
- **Priority:** `stop` > `pause` > `start` > timer expiry.
  - `stop` in any state: IDLE next cycle, step=0, play=0, no `done` pulse.
  - `start` while busy is ignored.
  - `pause` in IDLE or LOAD is ignored.
- **Arithmetic:** the duration counter is 3+log2(BEAT_TICKS) bits and never overflows. beat_period is floored at 1 so a shift to 0 is impossible.

## Timing
- All outputs are registered. Reset values:
  - state=IDLE; note_index=0, play=0, busy=0, step=0, done=0;
  - all counters and the saved state are cleared.
- `rst` mid-song has the same effect as reset on the next edge. It overrides `stop` and `start` in the same cycle.
- With `start` high in cycle 0:
  - cycle 1 is LOAD (busy=1);
  - the first PLAY cycle is cycle 2, with note_index valid and play=1.
- Entry-to-entry overhead is GAP_TICKS + 1 (LOAD) cycles.
- `done` is exactly one cycle wide and coincides with busy falling.

## Structure
- Shared package `song_pkg`:
  - state enum;
  - song entry struct {note[5:0], rest, beats[2:0]};
  - END_MARKER constant;
  - note constants C4..C5 = 0..7.
- Sub-module `song_rom`: combinational case ROM indexed by step, parameterised by SONG_SEL.
  - SONG_SEL=1 content: {3, no rest, 2 beats}, {rest, 1 beat}, {7, no rest, 1 beat}, end marker.
- Top-level integration: the existing top muxes `song_sequencer.note_index`/`play` against the manual path under a mode switch.

## Test plan
All scenarios use BEAT_TICKS=8, GAP_TICKS=2, SONG_SEL=1, tempo_sel=0.
- **Basic song:** start in cycle 0 ->
  - LOAD at 1;
  - note 3 with play=1 for cycles 2–17;
  - GAP at 18–19;
  - rest with play=0 for 21–28;
  - note 7 with play=1 for 32–39;
  - done=1 only in cycle 43, busy=0 from 43.
- **Loop:** loop_en=1 -> after the end marker, step=0 and note 3 plays again from cycle 44. done is never asserted.
- **Pause/resume:** pause in cycle 6, resume in cycle 20 -> play=0 for cycles 7–20, then note 3 plays for the remaining 11 cycles (21–31).
- **Stop priority:** stop and pause together in cycle 10 -> IDLE at 11, play=0, step=0, done=0. A later start replays from step 0.
- **Tempo:** tempo_sel=1 -> note 3 plays for 8 cycles (2–9). tempo_sel=3 changed mid-note -> applies only from the next LOAD.
- **Reset and ignored start:** rst in cycle 25 -> all outputs at reset values in cycle 26. start while busy -> no effect on step or timing.
